// File: rtl/step_pulse_gen_pkg.sv
// Shared axis definitions: pulse-generator FSM states and default widths.
// Pure declarations; no timing or backpressure of its own.
package step_pulse_gen_pkg;

  localparam int STEP_CNT_WIDTH   = 16;
  localparam int STEP_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } step_state_t;

endpackage

// File: rtl/step_tick_counter.sv
// Loadable down-counter advanced by clk_en; load wins over decrement, holds at zero.
// Latency: load visible next cycle; no backpressure.
module step_tick_counter
  import step_pulse_gen_pkg::*;
#(
  parameter int CNT_WIDTH = STEP_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 is_zero
);

  logic [CNT_WIDTH-1:0] cnt;

  assign is_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clk_en && !is_zero) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Stepper pulse generator: emits cmd_steps pulses of PULSE_TICKS high per eff_period ticks.
// Latency: step rises the cycle after accept; cmd_ready low (command held off) until back in IDLE.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int CNT_WIDTH   = STEP_CNT_WIDTH,
  parameter int STEPS_WIDTH = STEP_COUNT_WIDTH,
  parameter int PULSE_TICKS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [STEPS_WIDTH-1:0] cmd_steps,
  input  logic                   cmd_dir,
  input  logic [CNT_WIDTH-1:0]   cmd_period,
  output logic                   step,
  output logic                   dir,
  output logic                   busy,
  output logic                   done
);

  localparam logic [CNT_WIDTH-1:0]   PULSE_W     = CNT_WIDTH'(PULSE_TICKS);
  localparam logic [CNT_WIDTH-1:0]   HIGH_RELOAD = CNT_WIDTH'(PULSE_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0]   MIN_PERIOD  = CNT_WIDTH'(PULSE_TICKS + 1);
  localparam logic [STEPS_WIDTH-1:0] ONE_STEP    = STEPS_WIDTH'(1);

  step_state_t            state;
  logic [STEPS_WIDTH-1:0] steps_left;
  logic [CNT_WIDTH-1:0]   eff_period;
  logic [CNT_WIDTH-1:0]   load_val;
  logic                   load;
  logic                   is_zero;
  logic                   accept;
  logic                   tick_end;

  assign accept    = (state == IDLE) && cmd_valid;
  assign tick_end  = clk_en && is_zero;
  assign step      = (state == HIGH);
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign cmd_ready = !busy;

  // Clamp guarantees the LOW reload (eff_period - PULSE_TICKS - 1) never underflows.
  always_comb begin
    load     = 1'b0;
    load_val = HIGH_RELOAD;
    case (state)
      IDLE: load = accept && (cmd_steps != '0);
      HIGH: begin
        load     = tick_end;
        load_val = eff_period - PULSE_W - CNT_WIDTH'(1);
      end
      LOW:     load = tick_end && (steps_left != ONE_STEP);
      default: load = 1'b0;
    endcase
  end

  step_tick_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_tick_counter (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .load     (load),
    .load_val (load_val),
    .is_zero  (is_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      steps_left <= '0;
      eff_period <= '0;
      dir        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dir        <= cmd_dir;
            steps_left <= cmd_steps;
            eff_period <= (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
            state      <= (cmd_steps == '0) ? DONE : HIGH;
          end
        end
        HIGH: begin
          if (tick_end) state <= LOW;
        end
        LOW: begin
          if (tick_end) begin
            steps_left <= steps_left - ONE_STEP;
            state      <= (steps_left == ONE_STEP) ? DONE : HIGH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: expected step edges and done pulses, expressed in clk_en ticks
// counted from the cycle after accept, are queued per command and matched by a monitor.
module tb_step_pulse_gen;

  localparam int PT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_period = '0;
  logic        step, dir, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int en_mode = 0;
  int cyc_n = 0;

  typedef struct {
    int kind;   // 0 rise, 1 fall, 2 done
    int off;    // ticks since move start
    bit d;
  } ev_t;
  ev_t q[$];

  always #5 clk = ~clk;

  step_pulse_gen #(
    .CNT_WIDTH(16), .STEPS_WIDTH(16), .PULSE_TICKS(PT)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps),
    .cmd_dir(cmd_dir), .cmd_period(cmd_period),
    .step(step), .dir(dir), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Move model: pulse i rises after i*eff ticks, falls PT ticks later, done after steps*eff.
  task automatic push_move(input int steps, input bit d, input int per);
    int eff;
    eff = (per < PT + 1) ? PT + 1 : per;
    for (int i = 0; i < steps; i++) begin
      q.push_back('{0, i * eff, d});
      q.push_back('{1, i * eff + PT, d});
    end
    q.push_back('{2, steps * eff, d});
  endtask

  // Monitor state
  int ticks = 0;
  bit exp_busy = 0;
  bit exp_dir = 0;
  bit prev_step = 0;
  bit rst_prev = 0;

  task automatic match(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d at tick %0d, expected no event", kind, ticks);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_tick", ticks, e.off);
      if (kind == 0) chk("rise_dir", dir, e.d);
    end
  endtask

  always @(negedge clk) begin
    if (rst_prev) begin
      chk("rst_step", step, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_dir", dir, 0);
    end
    if (!reset) begin
      q.delete();
      exp_busy  = 0;
      exp_dir   = 0;
      prev_step = 0;
      rst_prev  = 1;
    end else begin
      rst_prev = 0;
      chk("busy", busy, exp_busy);
      chk("cmd_ready", cmd_ready, !exp_busy);
      chk("dir", dir, exp_dir);
      if (step != prev_step) match(step ? 0 : 1);
      if (done) match(2);
      prev_step = step;
      if (exp_busy) ticks += clk_en;
      if (cmd_valid && !exp_busy) begin
        exp_busy = 1;
        exp_dir  = cmd_dir;
        ticks    = 0;
      end else if (done) begin
        exp_busy = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    case (en_mode)
      0:       clk_en = 1'b1;
      1:       clk_en = (cyc_n % 3 == 0);
      default: clk_en = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send(input int steps, input bit d, input int per);
    bit ok = 0;
    push_move(steps, d, per);
    cmd_valid  = 1'b1;
    cmd_steps  = 16'(steps);
    cmd_dir    = d;
    cmd_period = 16'(per);
    for (int n = 0; n < 600 && !ok; n++) begin
      if (cmd_ready) ok = 1;
      cyc();
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got no accept in 600 cycles, expected accept");
    end
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 0;
    for (int n = 0; n < bound && !ok; n++) begin
      if (q.size() == 0 && !busy) ok = 1;
      else cyc();
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got %0d pending events busy=%0d, expected drained", q.size(), busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with a command presented: nothing may be accepted.
    cmd_valid  = 1'b1;
    cmd_steps  = 16'd3;
    cmd_dir    = 1'b1;
    cmd_period = 16'd10;
    repeat (4) cyc();
    cmd_valid = 1'b0;
    reset     = 1'b1;
    repeat (2) cyc();

    en_mode = 0;
    send(3, 1'b1, 10);
    wait_idle(200);
    send(2, 1'b0, 2);
    wait_idle(200);
    send(0, 1'b1, 9);
    wait_idle(50);

    // Sparse enable with the handshake landing on a clk_en=0 cycle.
    en_mode = 1;
    for (int n = 0; n < 4 && clk_en; n++) cyc();
    send(1, 1'b1, 6);
    wait_idle(200);

    // Second command held while busy; dir only changes on its accept.
    en_mode = 0;
    send(2, 1'b1, 6);
    send(1, 1'b0, 7);
    wait_idle(200);

    // Reset during the second HIGH of a 5-step move.
    begin
      int  r = 0;
      bit  p = 0;
      send(5, 1'b1, 8);
      for (int n = 0; n < 200 && r < 2; n++) begin
        if (step && !p) r++;
        p = step;
        if (r < 2) cyc();
      end
      chk("midmove_second_rise", r, 2);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      repeat (20) cyc();
      wait_idle(50);
    end

    for (int i = 0; i < 25; i++) begin
      en_mode = int'($urandom_range(0, 2));
      send(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)));
      if ($urandom_range(0, 1) == 1) wait_idle(400);
    end
    wait_idle(1000);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
